// File: rtl/test_mem_dma_sequencer.sv
// Two-requester round-robin transfer sequencer for the test memory device.
// Drives the write or read side with a clean enable edge and reports done/error.
module test_mem_dma_sequencer #(
    parameter int TIMEOUT = 4096,
    parameter int SETTLE  = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   req,
    input  logic [1:0]   req_dir,
    input  logic [127:0] req_addr,
    input  logic [47:0]  req_count,
    input  logic [3:0]   req_mode,
    output logic [1:0]   ack,
    output logic [1:0]   done,
    output logic [1:0]   error,
    output logic         busy,
    output logic         write_enable,
    output logic         read_enable,
    output logic [63:0]  write_addr,
    output logic [63:0]  read_addr,
    output logic [23:0]  write_count,
    output logic [23:0]  read_count,
    output logic         write_addr_inc,
    output logic         write_addr_dec,
    output logic         read_addr_inc,
    output logic         read_addr_dec,
    input  logic         write_finished,
    input  logic         read_finished
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        ENABLE = 3'd2,
        WAIT   = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic [23:0] TMO_LAST    = 24'(TIMEOUT - 1);
    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE - 1);

    state_t      state_r;
    logic        owner_r;
    logic        rr_last_r;
    logic        dir_r;
    logic        zero_r;
    logic [15:0] settle_cnt_r;
    logic [23:0] tcnt_r;

    logic        winner_s;
    logic        w_dir_s;
    logic [63:0] w_addr_s;
    logic [23:0] w_count_s;
    logic [1:0]  w_mode_s;
    logic        finished_s;

    function automatic logic [1:0] ch_onehot(input logic ch);
        return ch ? 2'b10 : 2'b01;
    endfunction

    // Round-robin winner and its command fields
    always_comb begin
        winner_s = 1'b0;
        if (req == 2'b11) begin
            winner_s = ~rr_last_r;
        end else if (req[0]) begin
            winner_s = 1'b0;
        end else begin
            winner_s = 1'b1;
        end
        if (winner_s) begin
            w_dir_s   = req_dir[1];
            w_addr_s  = req_addr[127:64];
            w_count_s = req_count[47:24];
            w_mode_s  = req_mode[3:2];
        end else begin
            w_dir_s   = req_dir[0];
            w_addr_s  = req_addr[63:0];
            w_count_s = req_count[23:0];
            w_mode_s  = req_mode[1:0];
        end
    end

    assign finished_s = dir_r ? read_finished : write_finished;

    // Sequencer FSM with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= IDLE;
            owner_r        <= 1'b0;
            rr_last_r      <= 1'b1;
            dir_r          <= 1'b0;
            zero_r         <= 1'b0;
            settle_cnt_r   <= 16'd0;
            tcnt_r         <= 24'd0;
            ack            <= 2'b00;
            done           <= 2'b00;
            error          <= 2'b00;
            busy           <= 1'b0;
            write_enable   <= 1'b0;
            read_enable    <= 1'b0;
            write_addr     <= 64'd0;
            read_addr      <= 64'd0;
            write_count    <= 24'd0;
            read_count     <= 24'd0;
            write_addr_inc <= 1'b0;
            write_addr_dec <= 1'b0;
            read_addr_inc  <= 1'b0;
            read_addr_dec  <= 1'b0;
        end else begin
            ack   <= 2'b00;
            done  <= 2'b00;
            error <= 2'b00;
            case (state_r)
                IDLE: begin
                    if (|req) begin
                        owner_r   <= winner_s;
                        rr_last_r <= winner_s;
                        dir_r     <= w_dir_s;
                        ack       <= ch_onehot(winner_s);
                        busy      <= 1'b1;
                        if (w_dir_s) begin
                            read_addr     <= w_addr_s;
                            read_count    <= w_count_s;
                            read_addr_inc <= (w_mode_s == 2'b01);
                            read_addr_dec <= (w_mode_s == 2'b10);
                        end else begin
                            write_addr     <= w_addr_s;
                            write_count    <= w_count_s;
                            write_addr_inc <= (w_mode_s == 2'b01);
                            write_addr_dec <= (w_mode_s == 2'b10);
                        end
                        // A zero-length command completes without ever raising an enable
                        if (w_count_s == 24'd0) begin
                            zero_r  <= 1'b1;
                            state_r <= DONE;
                        end else begin
                            zero_r  <= 1'b0;
                            state_r <= LOAD;
                        end
                    end else begin
                        busy <= 1'b0;
                    end
                end
                LOAD: begin
                    settle_cnt_r <= 16'd0;
                    write_enable <= ~dir_r;
                    read_enable  <= dir_r;
                    state_r      <= ENABLE;
                end
                ENABLE: begin
                    if (settle_cnt_r == SETTLE_LAST) begin
                        tcnt_r  <= 24'd0;
                        state_r <= WAIT;
                    end else begin
                        settle_cnt_r <= settle_cnt_r + 16'd1;
                    end
                end
                WAIT: begin
                    if (finished_s) begin
                        write_enable <= 1'b0;
                        read_enable  <= 1'b0;
                        done         <= ch_onehot(owner_r);
                        state_r      <= DONE;
                    end else if (tcnt_r == TMO_LAST) begin
                        write_enable <= 1'b0;
                        read_enable  <= 1'b0;
                        error        <= ch_onehot(owner_r);
                        state_r      <= DONE;
                    end else if (tcnt_r != 24'hFF_FFFF) begin
                        tcnt_r <= tcnt_r + 24'd1;
                    end
                end
                DONE: begin
                    if (zero_r) begin
                        done <= ch_onehot(owner_r);
                    end
                    zero_r  <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    write_enable <= 1'b0;
                    read_enable  <= 1'b0;
                    busy         <= 1'b0;
                    state_r      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/test_mem_dma_sequencer.md
# test_mem_dma_sequencer

Two-requester transfer sequencer for the test memory device. It arbitrates round-robin between two command ports and drives the device's write side (FIFO→memory) or read side (memory→FIFO) with address, count, address mode and a clean enable rising edge. It waits for completion under a timeout and returns a per-requester done or error pulse. It sits between the DMA test harness command logic and the memory device's control inputs; the data FIFOs are untouched.

## Interface
- `TIMEOUT`, 4096: cycles allowed in WAIT before abort; must be ≥ 4.
- `SETTLE`, 2: cycles enable is held high before completion is sampled; must be ≥ 1.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  2  per-channel command request; level, held until `ack`.
- `req_dir`  in  2  per channel: 0 = write into memory, 1 = read from memory.
- `req_addr`  in  128  channel n uses bits [64n+63:64n].
- `req_count`  in  48  channel n uses bits [24n+23:24n]; words.
- `req_mode`  in  4  channel n uses bits [2n+1:2n]: 00 fixed, 01 increment, 10 decrement, 11 treated as fixed.
- `ack`  out  2  one-cycle pulse; command latched.
- `done`  out  2  one-cycle pulse; transfer completed.
- `error`  out  2  one-cycle pulse; transfer timed out.
- `busy`  out  1  high in every state except IDLE.
- `write_enable`, `read_enable`  out  1  device enables.
- `write_addr`, `read_addr`  out  64  latched address.
- `write_count`, `read_count`  out  24  latched count.
- `write_addr_inc`, `write_addr_dec`, `read_addr_inc`, `read_addr_dec`  out  1  decoded from the latched mode.
- `write_finished`  in  1  device write-side completion.
- `read_finished`  in  1  device read-side completion (mem_read_count ≥ count).

## Operation
- States: IDLE, LOAD, ENABLE, WAIT, DONE.
- IDLE: when any `req` bit is high, grant round-robin.
  - Round-robin: priority goes to the channel not granted last; the pointer resets to 1 so channel 0 wins first.
  - On grant: latch dir/addr/count/mode of the winner, pulse `ack[winner]`, go to LOAD.
- Zero count: the grant goes from IDLE directly to DONE with no enable asserted. `done` is still pulsed.
- LOAD: both enables low for exactly 1 cycle, with addr/count/mode already driven. This guarantees the device sees a rising edge even for back-to-back commands. Go to ENABLE.
- ENABLE: assert the enable selected by `dir`. Hold `SETTLE` cycles; the device's stale finished flag is ignored here. Go to WAIT.
- WAIT: enable stays high.
  - Selected finished input high → DONE (success).
  - Timeout counter reaches `TIMEOUT`-1 → DONE (error).
  - Finished has priority if both occur on the same cycle.
- DONE: deassert the enable, pulse `done[owner]` or `error[owner]`, return to IDLE.
  - A new request is not granted in this same cycle.
- Address and count outputs hold their last latched values until the next grant. Mode decode outputs are likewise held.
- The unselected side's enable stays low throughout.
- Timeout counter: 24-bit, clears on entry to WAIT, saturates.

## Timing
- Reset values: all enables/ack/done/error/busy = 0; addr = 0; count = 0; inc/dec = 0; state IDLE; RR pointer = 1.
- `rst` mid-transfer: next edge forces reset values. The enable drops in the same cycle; no done or error is issued.
- Request at cycle t in IDLE:
  - `ack` at t+1 and LOAD at t+1.
  - Enable rises at t+2.
  - Completion is first sampled at t+2+`SETTLE`.
- Finished sampled high at cycle f: `done` and enable-low at f+1.
- Zero-count command: `ack` at t+1, `done` at t+2.
- Minimum back-to-back spacing between grants: 5+`SETTLE` cycles.
- `req` deasserted before `ack`: the command is dropped with no pulse. It is ignored after ack.

## Test plan
- Single write: ch0 req, dir=0, addr=0x10, count=8, mode=01; finished asserted 12 cycles after enable → `ack[0]` at t+1, `write_enable` high t+2..done cycle, `write_addr_inc`=1, `done[0]` once, `read_enable` never high.
- Round-robin: both channels request continuously, ch1 dir=1 count=4 → grant order 0,1,0,1. An enable low cycle (LOAD) precedes each rise.
- Stale finished: `write_finished` held high before the command → no completion during the `SETTLE` cycles; `done` no earlier than t+3+`SETTLE`.
- Timeout: `TIMEOUT`=16, finished never asserted → `error[0]` pulse exactly 16 cycles after WAIT entry, enable low, `done` not pulsed.
- Zero count and decrement: count=0 → `done` at t+2 with no enable. Next command mode=10 → `write_addr_dec`=1, `write_addr_inc`=0.
- Reset mid-WAIT: `rst` pulsed → enables, `busy` and pulses at 0 the next cycle. A subsequent ch1-only request is granted normally.
